// File: rtl/gam_assoc_sequencer.sv
// Front-end sequencer for the GAM associative layer: buffers key/response pairs
// and issues key-learn, settle gap, response-learn, then waits for learning-done.
module gam_assoc_sequencer #(
  parameter int CLASS_W    = 8,
  parameter int VEC_W      = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int KEY_GAP    = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pair_valid,
  output logic               pair_ready,
  input  logic [VEC_W-1:0]   key_vec,
  input  logic [CLASS_W-1:0] key_class,
  input  logic [VEC_W-1:0]   resp_vec,
  input  logic [CLASS_W-1:0] resp_class,
  input  logic               flush,
  output logic [VEC_W-1:0]   al_x,
  output logic [CLASS_W-1:0] al_c,
  output logic               al_key_response,
  output logic               al_start,
  input  logic               al_done,
  output logic               busy,
  output logic [15:0]        pair_count,
  output logic               timeout_err
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int GAP_W   = (KEY_GAP > 1) ? $clog2(KEY_GAP + 1) : 1;
  localparam int TMR_W   = $clog2(TIMEOUT + 1);
  localparam int ENTRY_W = 2 * (VEC_W + CLASS_W);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(KEY_GAP - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_ISSUE,
    S_KEY_WAIT,
    S_RESP_ISSUE,
    S_RESP_WAIT
  } state_e;

  state_e               state_q;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 pair_ready_q;
  logic                 push, pop;

  logic [VEC_W-1:0]     head_kv, head_rv;
  logic [CLASS_W-1:0]   head_kc, head_rc;
  logic [VEC_W-1:0]     resp_vec_q;
  logic [CLASS_W-1:0]   resp_class_q;

  logic [GAP_W-1:0]     gap_q;
  logic [TMR_W-1:0]     tmr_q;
  logic [VEC_W-1:0]     al_x_q;
  logic [CLASS_W-1:0]   al_c_q;
  logic                 al_kr_q, al_start_q, busy_q, timeout_err_q;
  logic [15:0]          pair_count_q;

  assign {head_kv, head_kc, head_rv, head_rc} = mem_q[rd_ptr_q];

  // Flush overrides both sides: queued pairs are dropped and a same-cycle push is lost.
  always_comb begin
    push    = pair_valid & pair_ready_q & ~flush;
    pop     = (state_q == S_IDLE) & (count_q != '0) & ~flush;
    count_d = count_q;
    if (flush)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !push)
      count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
    if (rst) begin
      count_q      <= '0;
      pair_ready_q <= 1'b1;
    end else begin
      count_q      <= count_d;
      pair_ready_q <= (count_d != DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {key_vec, key_class, resp_vec, resp_class};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      al_start_q    <= 1'b0;
      al_kr_q       <= 1'b0;
      al_x_q        <= '0;
      al_c_q        <= '0;
      gap_q         <= '0;
      tmr_q         <= '0;
      pair_count_q  <= '0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      al_start_q <= 1'b0;
      busy_q     <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q      <= S_KEY_ISSUE;
            al_start_q   <= 1'b1;
            al_kr_q      <= 1'b0;
            al_x_q       <= head_kv;
            al_c_q       <= head_kc;
            resp_vec_q   <= head_rv;
            resp_class_q <= head_rc;
          end else begin
            busy_q <= (count_d != '0);
          end
        end
        S_KEY_ISSUE: begin
          gap_q   <= '0;
          state_q <= S_KEY_WAIT;
        end
        S_KEY_WAIT: begin
          if (gap_q == GAP_LAST) begin
            state_q    <= S_RESP_ISSUE;
            al_start_q <= 1'b1;
            al_kr_q    <= 1'b1;
            al_x_q     <= resp_vec_q;
            al_c_q     <= resp_class_q;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        S_RESP_ISSUE: begin
          tmr_q   <= '0;
          state_q <= S_RESP_WAIT;
        end
        S_RESP_WAIT: begin
          // Done is checked first so it wins over a coincident timeout.
          if (al_done) begin
            pair_count_q <= pair_count_q + 16'd1;
            state_q      <= S_IDLE;
            busy_q       <= (count_d != '0);
          end else if (tmr_q == TMR_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
            busy_q        <= (count_d != '0);
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pair_ready      = pair_ready_q;
  assign al_x            = al_x_q;
  assign al_c            = al_c_q;
  assign al_key_response = al_kr_q;
  assign al_start        = al_start_q;
  assign busy            = busy_q;
  assign pair_count      = pair_count_q;
  assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_gam_assoc_sequencer.sv
// Directed bench for gam_assoc_sequencer: latency, FIFO back-pressure, timeout,
// done/timeout tie, reset mid-sequence and flush behaviour.
module tb_gam_assoc_sequencer;

  logic        clk = 1'b0;
  logic        rst, pair_valid, flush, al_done;
  logic        pair_ready, al_key_response, al_start, busy, timeout_err;
  logic [63:0] key_vec, resp_vec, al_x;
  logic [7:0]  key_class, resp_class, al_c;
  logic [15:0] pair_count;

  int n_checks = 0;
  int n_errors = 0;

  gam_assoc_sequencer dut (
    .clk(clk), .rst(rst), .pair_valid(pair_valid), .pair_ready(pair_ready),
    .key_vec(key_vec), .key_class(key_class), .resp_vec(resp_vec),
    .resp_class(resp_class), .flush(flush), .al_x(al_x), .al_c(al_c),
    .al_key_response(al_key_response), .al_start(al_start), .al_done(al_done),
    .busy(busy), .pair_count(pair_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] kv(input logic [7:0] c);
    return 64'hA5A5_0000_0000_0000 | {56'd0, c};
  endfunction

  function automatic logic [63:0] rv(input logic [7:0] c);
    return 64'h5A5A_0000_0000_0000 | {56'd0, c};
  endfunction

  task automatic drive_pair(input logic [7:0] kc, input logic [7:0] rc);
    pair_valid = 1'b1;
    key_class  = kc;
    resp_class = rc;
    key_vec    = kv(kc);
    resp_vec   = rv(rc);
  endtask

  // Wait (bounded) for a start pulse of the given kind, then check its payload.
  task automatic wait_start(input logic kr, input logic [7:0] cls, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (al_start && al_key_response == kr) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_seen"}, seen, 1'b1);
    chk({tag, "_cls"}, al_c, cls);
    chk({tag, "_x"}, al_x, kr ? rv(cls) : kv(cls));
  endtask

  task automatic no_start_for(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (al_start) seen = 1'b1;
    end
    chk(tag, seen, 1'b0);
  endtask

  initial begin
    rst = 1'b1; pair_valid = 1'b0; flush = 1'b0; al_done = 1'b0;
    key_vec = '0; resp_vec = '0; key_class = '0; resp_class = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_start", al_start, 1'b0);
    chk("rst_ready", pair_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", pair_count, 16'd0);
    chk("rst_err", timeout_err, 1'b0);
    chk("rst_alc", al_c, 8'd0);

    // Single pair: key start 2 edges after accept, response 3 edges later.
    drive_pair(8'd3, 8'd7);
    tick();
    pair_valid = 1'b0;
    chk("t1_busy", busy, 1'b1);
    chk("t1_idle_start", al_start, 1'b0);
    tick();
    chk("t1_key_start", al_start, 1'b1);
    chk("t1_key_c", al_c, 8'd3);
    chk("t1_key_kr", al_key_response, 1'b0);
    chk("t1_key_x", al_x, kv(8'd3));
    tick();
    chk("t1_gap1_start", al_start, 1'b0);
    chk("t1_gap1_c", al_c, 8'd3);
    tick();
    chk("t1_gap2_start", al_start, 1'b0);
    tick();
    chk("t1_resp_start", al_start, 1'b1);
    chk("t1_resp_c", al_c, 8'd7);
    chk("t1_resp_kr", al_key_response, 1'b1);
    chk("t1_resp_x", al_x, rv(8'd7));
    tick();
    al_done = 1'b1;
    tick();
    al_done = 1'b0;
    chk("t1_count", pair_count, 16'd1);
    chk("t1_busy_low", busy, 1'b0);
    chk("t1_hold_c", al_c, 8'd7);
    chk("t1_hold_kr", al_key_response, 1'b1);

    // Back-pressure: valid held 6 cycles, only 5 accepted.
    for (int i = 0; i < 6; i++) begin
      drive_pair(8'(10 + i), 8'(20 + i));
      chk($sformatf("t2_ready%0d", i), pair_ready, i < 5);
      tick();
      chk($sformatf("t2_start%0d", i), al_start, (i == 1 || i == 4));
    end
    pair_valid = 1'b0;
    chk("t2_p0_resp_c", al_c, 8'd20);
    al_done = 1'b1;
    tick();
    al_done = 1'b0;
    chk("t2_count0", pair_count, 16'd2);
    for (int k = 1; k < 5; k++) begin
      wait_start(1'b0, 8'(10 + k), $sformatf("t2_key%0d", k));
      wait_start(1'b1, 8'(20 + k), $sformatf("t2_resp%0d", k));
      tick();
      al_done = 1'b1;
      tick();
      al_done = 1'b0;
      chk($sformatf("t2_count%0d", k), pair_count, 16'(2 + k));
    end
    chk("t2_busy_low", busy, 1'b0);
    no_start_for(10, "t2_no_sixth");

    // Timeout, then the next queued pair runs normally.
    drive_pair(8'd30, 8'd31);
    tick();
    drive_pair(8'd40, 8'd41);
    tick();
    pair_valid = 1'b0;
    wait_start(1'b0, 8'd30, "t3_key");
    wait_start(1'b1, 8'd31, "t3_resp");
    repeat (15) tick();
    chk("t3_err_early", timeout_err, 1'b0);
    tick();
    chk("t3_err", timeout_err, 1'b1);
    chk("t3_count", pair_count, 16'd6);
    chk("t3_busy", busy, 1'b1);
    wait_start(1'b0, 8'd40, "t3_next_key");
    wait_start(1'b1, 8'd41, "t3_next_resp");
    tick();
    al_done = 1'b1;
    tick();
    al_done = 1'b0;
    chk("t3_next_count", pair_count, 16'd7);
    chk("t3_err_sticky", timeout_err, 1'b1);

    // Reset in KEY_WAIT with two pairs queued.
    for (int i = 0; i < 3; i++) begin
      drive_pair(8'(50 + i), 8'(150 + i));
      tick();
    end
    pair_valid = 1'b0;
    chk("t5_pre_c", al_c, 8'd50);
    chk("t5_pre_start", al_start, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_start", al_start, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_count", pair_count, 16'd0);
    chk("t5_err", timeout_err, 1'b0);
    chk("t5_ready", pair_ready, 1'b1);
    no_start_for(20, "t5_no_start");

    // Done on the final RESP_WAIT cycle wins over timeout.
    drive_pair(8'd60, 8'd160);
    tick();
    pair_valid = 1'b0;
    wait_start(1'b0, 8'd60, "t4_key");
    wait_start(1'b1, 8'd160, "t4_resp");
    repeat (15) tick();
    al_done = 1'b1;
    tick();
    al_done = 1'b0;
    chk("t4_count", pair_count, 16'd1);
    chk("t4_err", timeout_err, 1'b0);
    chk("t4_busy", busy, 1'b0);

    // Flush with 3 queued + 1 in flight; a same-cycle push is dropped.
    for (int i = 0; i < 5; i++) begin
      drive_pair(8'(70 + i), 8'(170 + i));
      flush = (i == 4);
      tick();
    end
    pair_valid = 1'b0;
    flush = 1'b0;
    chk("t6_resp_start", al_start, 1'b1);
    chk("t6_resp_c", al_c, 8'd170);
    chk("t6_busy", busy, 1'b1);
    chk("t6_ready", pair_ready, 1'b1);
    tick();
    al_done = 1'b1;
    repeat (4) tick();
    al_done = 1'b0;
    chk("t6_count", pair_count, 16'd2);
    chk("t6_busy_low", busy, 1'b0);
    no_start_for(20, "t6_no_start");
    chk("t6_count_final", pair_count, 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
